// File: rtl/adc_clk_gen_multi_pkg.sv
// Shared constants and types for the multi-channel ADC sample-clock generator.
// Holds default parameter values, channel-index width and reset level.
package adc_clk_gen_multi_pkg;

  localparam int   DEF_NUM_CH = 4;
  localparam int   DEF_DIV_W  = 16;
  localparam int   DEF_HALF   = 3;
  localparam int   CH_IDX_W   = 4;
  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

endpackage

// File: rtl/adc_clk_gen_multi_if.sv
// Control/config inputs and generated clock/strobe outputs of the clock generator.
// master = register block / test driver side, slave = generator side.
interface adc_clk_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  import adc_clk_gen_multi_pkg::*;

  logic [NUM_CH-1:0]   ch_en;
  logic                sync_i;
  logic                cfg_wr;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [DIV_W-1:0]    cfg_hi;
  logic [DIV_W-1:0]    cfg_lo;
  logic [NUM_CH-1:0]   cfg_pend;
  logic [NUM_CH-1:0]   adc_clk;
  logic [NUM_CH-1:0]   rise_stb;
  logic [NUM_CH-1:0]   fall_stb;

  modport master (
    output ch_en, sync_i, cfg_wr, cfg_ch, cfg_hi, cfg_lo,
    input  cfg_pend, adc_clk, rise_stb, fall_stb
  );

  modport slave (
    input  ch_en, sync_i, cfg_wr, cfg_ch, cfg_hi, cfg_lo,
    output cfg_pend, adc_clk, rise_stb, fall_stb
  );

endinterface

// File: rtl/adc_clk_gen_multi_div_ch.sv
// One programmable clock channel: high/low phase lengths, pending config applied at boundaries.
// Outputs are registered, one cycle after the causing input; no backpressure.
module adc_clk_div_ch
  import adc_clk_gen_multi_pkg::*;
#(
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_hi,
  input  logic [DIV_W-1:0] i_lo,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_pend
);

  localparam logic [DIV_W-1:0] HALF_INIT = DIV_W'(DEFAULT_HALF);

  phase_t           r_ph;
  phase_t           w_ph_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_hi_act;
  logic [DIV_W-1:0] r_lo_act;
  logic [DIV_W-1:0] r_hi_pnd;
  logic [DIV_W-1:0] r_lo_pnd;
  logic             r_pnd;
  logic             r_en_q;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_apply;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ACTIVE) r_ph <= PH_LOW;
    else                       r_ph <= w_ph_nxt;
  end

  always_comb begin
    w_ph_nxt   = r_ph;
    w_cnt_nxt  = r_cnt;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    w_apply    = 1'b0;
    if (!i_en) begin
      w_ph_nxt   = PH_LOW;
      w_cnt_nxt  = '0;
      w_fall_nxt = (r_ph == PH_HIGH);
      w_apply    = r_pnd;
    end else if (!r_en_q || i_sync) begin
      // A channel already high just restarts its high phase without a new edge.
      w_ph_nxt   = PH_HIGH;
      w_cnt_nxt  = '0;
      w_rise_nxt = (r_ph == PH_LOW);
      w_apply    = r_pnd;
    end else if (r_ph == PH_HIGH) begin
      if (r_cnt >= r_hi_act) begin
        w_ph_nxt   = PH_LOW;
        w_cnt_nxt  = '0;
        w_fall_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
      end
    end else begin
      if (r_cnt >= r_lo_act) begin
        w_ph_nxt   = PH_HIGH;
        w_cnt_nxt  = '0;
        w_rise_nxt = 1'b1;
        w_apply    = r_pnd;
      end else begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    o_clk  = (r_ph == PH_HIGH);
    o_rise = r_rise;
    o_fall = r_fall;
    o_pend = r_pnd;
  end

  // A write landing on an apply edge stays pending; the apply uses the older value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ACTIVE) begin
      r_cnt    <= '0;
      r_en_q   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_pnd    <= 1'b0;
      r_hi_act <= HALF_INIT;
      r_lo_act <= HALF_INIT;
      r_hi_pnd <= HALF_INIT;
      r_lo_pnd <= HALF_INIT;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_en_q <= i_en;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      if (w_apply) begin
        r_hi_act <= r_hi_pnd;
        r_lo_act <= r_lo_pnd;
      end
      if (i_wr) begin
        r_hi_pnd <= i_hi;
        r_lo_pnd <= i_lo;
        r_pnd    <= 1'b1;
      end else if (w_apply) begin
        r_pnd <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_clk_gen_multi.sv
// Multi-channel ADC sample-clock generator: config decode, sync broadcast, per-channel dividers.
// Outputs registered one cycle after inputs; no backpressure.
module adc_clk_gen_multi
  import adc_clk_gen_multi_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic                wb_clk,
  input  logic                rst_pad_i,
  adc_clk_gen_multi_if.slave  bus
);

  logic [NUM_CH-1:0] w_clk;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_wr;
    // Indices at or above NUM_CH match no channel and are dropped.
    assign w_wr = bus.cfg_wr && (bus.cfg_ch == CH_IDX_W'(g));

    adc_clk_div_ch #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .i_clk   (wb_clk),
      .i_rst_n (rst_pad_i),
      .i_en    (bus.ch_en[g]),
      .i_sync  (bus.sync_i),
      .i_wr    (w_wr),
      .i_hi    (bus.cfg_hi),
      .i_lo    (bus.cfg_lo),
      .o_clk   (w_clk[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g]),
      .o_pend  (w_pend[g])
    );
  end

  assign bus.adc_clk  = w_clk;
  assign bus.rise_stb = w_rise;
  assign bus.fall_stb = w_fall;
  assign bus.cfg_pend = w_pend;

endmodule

// File: tb/tb_adc_clk_gen_multi.sv
// Directed bench for adc_clk_gen_multi with four channels and hand-computed waveforms.
module tb_adc_clk_gen_multi;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic wb_clk    = 1'b0;
  logic rst_pad_i = 1'b0;
  int   n_chk     = 0;
  int   n_pass    = 0;

  always #5 wb_clk = ~wb_clk;

  adc_clk_gen_multi_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

  adc_clk_gen_multi #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_HALF(3)) dut (
    .wb_clk    (wb_clk),
    .rst_pad_i (rst_pad_i),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_pad_i = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({bus.adc_clk, bus.rise_stb, bus.fall_stb, bus.cfg_pend} !== 16'h0)
      $display("FAIL reset_outputs clk/rise/fall/pend=%b/%b/%b/%b required all 0",
               bus.adc_clk, bus.rise_stb, bus.fall_stb, bus.cfg_pend);
    else n_pass++;
    rst_pad_i = 1'b1;
    tick();
    n_chk++;
    if (bus.adc_clk !== 4'b0000) $display("FAIL post_reset_idle clk=%b required 0000", bus.adc_clk);
    else n_pass++;
  endtask

  task automatic test_default_run();
    logic [3:0] ec, er, ef;
    bus.ch_en = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      tick();
      ec = (((k - 1) % 8) < 4)  ? 4'b0001 : 4'b0000;
      er = (((k - 1) % 8) == 0) ? 4'b0001 : 4'b0000;
      ef = (((k - 1) % 8) == 4) ? 4'b0001 : 4'b0000;
      n_chk++;
      if ({bus.adc_clk, bus.rise_stb, bus.fall_stb} !== {ec, er, ef})
        $display("FAIL default_run k=%0d clk/rise/fall=%b/%b/%b required %b/%b/%b",
                 k, bus.adc_clk, bus.rise_stb, bus.fall_stb, ec, er, ef);
      else n_pass++;
    end
  endtask

  task automatic test_cfg_ch0();
    logic tc [0:10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    logic tr [0:10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    logic tf [0:10] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic tp [0:10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    tick();
    tick();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd0; bus.cfg_hi = 16'd0; bus.cfg_lo = 16'd2;
    tick();
    bus.cfg_wr = 1'b0;
    n_chk++;
    if ({bus.cfg_pend, bus.adc_clk[0]} !== {4'b0001, 1'b1})
      $display("FAIL cfg0_pending pend=%b clk0=%b required 0001/1", bus.cfg_pend, bus.adc_clk[0]);
    else n_pass++;
    for (int j = 0; j <= 10; j++) begin
      tick();
      n_chk++;
      if ({bus.adc_clk[0], bus.rise_stb[0], bus.fall_stb[0], bus.cfg_pend[0]} !==
          {tc[j], tr[j], tf[j], tp[j]})
        $display("FAIL cfg0_wave j=%0d clk/rise/fall/pend=%b%b%b%b required %b%b%b%b", j,
                 bus.adc_clk[0], bus.rise_stb[0], bus.fall_stb[0], bus.cfg_pend[0],
                 tc[j], tr[j], tf[j], tp[j]);
      else n_pass++;
    end
  endtask

  task automatic test_last_wins();
    logic tc [0:12] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    logic tp [0:12] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bus.ch_en = 4'b0011;
    tick();
    n_chk++;
    if ({bus.adc_clk[1], bus.rise_stb[1]} !== 2'b11)
      $display("FAIL ch1_enable clk1/rise1=%b%b required 11", bus.adc_clk[1], bus.rise_stb[1]);
    else n_pass++;
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd1; bus.cfg_hi = 16'd5; bus.cfg_lo = 16'd5;
    tick();
    bus.cfg_hi = 16'd1; bus.cfg_lo = 16'd1;
    tick();
    bus.cfg_wr = 1'b0;
    for (int j = 0; j <= 12; j++) begin
      tick();
      n_chk++;
      if ({bus.adc_clk[1], bus.cfg_pend[1]} !== {tc[j], tp[j]})
        $display("FAIL last_wins r=%0d clk1/pend1=%b%b required %b%b", j + 4,
                 bus.adc_clk[1], bus.cfg_pend[1], tc[j], tp[j]);
      else n_pass++;
    end
  endtask

  task automatic test_sync();
    logic [3:0] ec [0:4] = '{4'b0111, 4'b0110, 4'b0100, 4'b0100, 4'b0011};
    logic [3:0] er [0:4] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
    logic [3:0] ef [0:4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0100};
    bus.ch_en = 4'b0000;
    tick();
    tick();
    n_chk++;
    if (bus.adc_clk !== 4'b0000) $display("FAIL all_disabled clk=%b required 0000", bus.adc_clk);
    else n_pass++;
    bus.ch_en = 4'b0111;
    tick();
    n_chk++;
    if ({bus.adc_clk, bus.rise_stb} !== {4'b0111, 4'b0111})
      $display("FAIL joint_enable clk/rise=%b/%b required 0111/0111", bus.adc_clk, bus.rise_stb);
    else n_pass++;
    for (int s = 2; s <= 6; s++) tick();
    n_chk++;
    if (bus.adc_clk !== 4'b0010) $display("FAIL pre_sync clk=%b required 0010", bus.adc_clk);
    else n_pass++;
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) tick();
      n_chk++;
      if ({bus.adc_clk, bus.rise_stb, bus.fall_stb} !== {ec[j], er[j], ef[j]})
        $display("FAIL sync_align s=%0d clk/rise/fall=%b/%b/%b required %b/%b/%b", j + 7,
                 bus.adc_clk, bus.rise_stb, bus.fall_stb, ec[j], er[j], ef[j]);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    n_chk++;
    if ({bus.adc_clk[2], bus.rise_stb[2]} !== 2'b11)
      $display("FAIL ch2_sync_rise clk2/rise2=%b%b required 11", bus.adc_clk[2], bus.rise_stb[2]);
    else n_pass++;
    bus.ch_en = 4'b0011;
    tick();
    n_chk++;
    if ({bus.adc_clk[2], bus.fall_stb[2]} !== 2'b01)
      $display("FAIL ch2_disable clk2/fall2=%b%b required 01", bus.adc_clk[2], bus.fall_stb[2]);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.adc_clk[2], bus.rise_stb[2], bus.fall_stb[2]} !== 3'b000)
      $display("FAIL ch2_held_off clk/rise/fall=%b%b%b required 000",
               bus.adc_clk[2], bus.rise_stb[2], bus.fall_stb[2]);
    else n_pass++;
    bus.ch_en = 4'b0111;
    tick();
    n_chk++;
    if ({bus.adc_clk[2], bus.rise_stb[2]} !== 2'b11)
      $display("FAIL ch2_reenable clk2/rise2=%b%b required 11", bus.adc_clk[2], bus.rise_stb[2]);
    else n_pass++;
  endtask

  task automatic test_bad_ch();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd15; bus.cfg_hi = 16'd0; bus.cfg_lo = 16'd0;
    tick();
    bus.cfg_wr = 1'b0;
    n_chk++;
    if (bus.cfg_pend !== 4'b0000) $display("FAIL bad_ch_pend pend=%b required 0000", bus.cfg_pend);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (bus.adc_clk[2] !== 1'b1) $display("FAIL bad_ch_high clk2=%b required 1", bus.adc_clk[2]);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.adc_clk[2], bus.fall_stb[2]} !== 2'b01)
      $display("FAIL bad_ch_fall clk2/fall2=%b%b required 01", bus.adc_clk[2], bus.fall_stb[2]);
    else n_pass++;
  endtask

  task automatic test_min_div();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd3; bus.cfg_hi = 16'd0; bus.cfg_lo = 16'd0;
    tick();
    bus.cfg_wr = 1'b0;
    n_chk++;
    if (bus.cfg_pend !== 4'b1000) $display("FAIL ch3_pend_set pend=%b required 1000", bus.cfg_pend);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.cfg_pend !== 4'b0000) $display("FAIL ch3_apply_off pend=%b required 0000", bus.cfg_pend);
    else n_pass++;
    bus.ch_en = 4'b1111;
    tick();
    n_chk++;
    if ({bus.adc_clk[3], bus.rise_stb[3]} !== 2'b11)
      $display("FAIL ch3_enable clk3/rise3=%b%b required 11", bus.adc_clk[3], bus.rise_stb[3]);
    else n_pass++;
    for (int i = 1; i <= 6; i++) begin
      logic hi;
      tick();
      hi = (i % 2 == 0);
      n_chk++;
      if ({bus.adc_clk[3], bus.rise_stb[3], bus.fall_stb[3]} !== {hi, hi, ~hi})
        $display("FAIL div2 i=%0d clk/rise/fall=%b%b%b required %b%b%b", i,
                 bus.adc_clk[3], bus.rise_stb[3], bus.fall_stb[3], hi, hi, ~hi);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] ec;
    #2;
    rst_pad_i = 1'b0;
    #1;
    n_chk++;
    if ({bus.adc_clk, bus.rise_stb, bus.fall_stb, bus.cfg_pend} !== 16'h0)
      $display("FAIL async_reset clk/rise/fall/pend=%b/%b/%b/%b required all 0",
               bus.adc_clk, bus.rise_stb, bus.fall_stb, bus.cfg_pend);
    else n_pass++;
    bus.ch_en = 4'b0001;
    tick();
    rst_pad_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      ec = (((k - 1) % 8) < 4) ? 4'b0001 : 4'b0000;
      n_chk++;
      if (bus.adc_clk !== ec)
        $display("FAIL default_restored k=%0d clk=%b required %b", k, bus.adc_clk, ec);
      else n_pass++;
    end
  endtask

  initial begin
    bus.ch_en  = '0;
    bus.sync_i = 1'b0;
    bus.cfg_wr = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_hi = '0;
    bus.cfg_lo = '0;
    test_reset();
    test_default_run();
    test_cfg_ch0();
    test_last_wins();
    test_sync();
    test_disable();
    test_bad_ch();
    test_min_div();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
